// File: rtl/mul_hilo_ctrl.sv
// rtl/mul_hilo_ctrl.sv - HI/LO register owner and sequencer for the multi-cycle multiplier
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   ex_valid, ex_op       EX-stage instruction: 0 NONE, 1 MULT, 2 MULTU, 3 MTHI,
//                         4 MTLO, 5 MFHI, 6 MFLO, 7 reserved (behaves as NONE)
//   ex_rs_data/rt_data    EX operands
//   flush                 pipeline flush, cancels an in-flight multiply
//   ex_stall              hold EX; instruction not accepted this cycle
//   mf_data               HI/LO read data for an accepted MFHI/MFLO, else 0
//   mul_start/op/op1/op2  held stable to the multiplier for MUL_LAT cycles
//   product               64-bit result from the multiplier
//   hi, lo                architectural HI/LO registers
module mul_hilo_ctrl #(
   parameter int MUL_LAT = 5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ex_valid,
   input  logic [2:0]  ex_op,
   input  logic [31:0] ex_rs_data,
   input  logic [31:0] ex_rt_data,
   input  logic        flush,
   output logic        ex_stall,
   output logic [31:0] mf_data,
   output logic        mul_start,
   output logic        mul_op,
   output logic [31:0] mul_op1,
   output logic [31:0] mul_op2,
   input  logic [63:0] product,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int CW = $clog2(MUL_LAT + 1);
   localparam logic [CW-1:0] LAT_C = CW'(MUL_LAT);
   localparam logic [CW-1:0] ONE_C = CW'(1);

   localparam logic [2:0] OP_NONE  = 3'd0;
   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_MTHI  = 3'd3;
   localparam logic [2:0] OP_MTLO  = 3'd4;
   localparam logic [2:0] OP_MFHI  = 3'd5;
   localparam logic [2:0] OP_MFLO  = 3'd6;
   localparam logic [2:0] OP_RSVD  = 3'd7;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   hi_q, hi_d;
   logic [31:0]   lo_q, lo_d;
   logic [31:0]   op1_q, op1_d;
   logic [31:0]   op2_q, op2_d;
   logic          mul_op_q, mul_op_d;

   logic          hilo_op;
   logic          stall_w;
   logic          accept;

   // Only HI/LO instructions can conflict with an in-flight multiply; a
   // flush drops the request, so there is nothing left to hold.
   assign hilo_op = ex_valid && (ex_op != OP_NONE) && (ex_op != OP_RSVD);
   assign stall_w = hilo_op && (state_q == S_BUSY) && !flush;
   assign accept  = hilo_op && !stall_w && !flush;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         op1_q    <= '0;
         op2_q    <= '0;
         mul_op_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         op1_q    <= op1_d;
         op2_q    <= op2_d;
         mul_op_q <= mul_op_d;
      end
   end

   // Next-state and datapath
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      op1_d    = op1_q;
      op2_d    = op2_q;
      mul_op_d = mul_op_q;

      if (flush) begin
         state_d = S_IDLE;
         cnt_d   = '0;
      end else if (state_q == S_BUSY) begin
         cnt_d = cnt_q - ONE_C;
         // Last multiplier cycle: product is valid at this edge.
         if (cnt_q == ONE_C) begin
            hi_d    = product[63:32];
            lo_d    = product[31:0];
            state_d = S_IDLE;
         end
      end else if (accept) begin
         // accept implies IDLE, since any HI/LO op while BUSY stalls
         case (ex_op)
            OP_MULT, OP_MULTU: begin
               op1_d    = ex_rs_data;
               op2_d    = ex_rt_data;
               mul_op_d = (ex_op == OP_MULT);
               cnt_d    = LAT_C;
               state_d  = S_BUSY;
            end
            OP_MTHI: hi_d = ex_rs_data;
            OP_MTLO: lo_d = ex_rs_data;
            default: ;
         endcase
      end
   end

   // Outputs
   always_comb begin
      ex_stall  = stall_w;
      mul_start = (state_q == S_BUSY);
      mul_op    = mul_op_q;
      mul_op1   = op1_q;
      mul_op2   = op2_q;
      hi        = hi_q;
      lo        = lo_q;
      mf_data   = '0;
      if (accept && ex_op == OP_MFHI) begin
         mf_data = hi_q;
      end else if (accept && ex_op == OP_MFLO) begin
         mf_data = lo_q;
      end
   end

endmodule
